scrambler_sync_ctrl: RTL and testbench

Lock/sync controller for the x^58+x^39+1 self-synchronizing descrambler on the receive path. It watches the descrambler output during idle/training traffic, where the expected payload is all-zero words. It declares lock after a run of clean words and drops lock on excessive errors. When no progress is made it forces a descrambler history flush. It also gates the descrambler enable and qualifies received data toward downstream logic.

---
 rtl/scrambler_sync_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_scrambler_sync_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrambler_sync_ctrl.sv
// Lock/sync controller for the x^58+x^39+1 self-synchronizing descrambler on the receive path.
// Optional bit-error counter enabled by defining SCRAMBLER_SYNC_BIT_ERR_EN.
module scrambler_sync_ctrl #(
  parameter int unsigned WIDTH        = 256,
  parameter int unsigned GOOD_CNT     = 8,
  parameter int unsigned BAD_LIMIT    = 4,
  parameter int unsigned WINDOW       = 64,
  parameter int unsigned HUNT_TIMEOUT = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             descram_ena,
  output logic             descram_flush,
  output logic             locked,
  output logic             dout_valid,
  output logic [7:0]       loss_cnt,
  output logic [1:0]       state,
  output logic [15:0]      bit_err_cnt
);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StLocked = 2'd1,
    StFlush  = 2'd2
  } state_e;

  localparam logic [7:0]  GoodCnt     = 8'(GOOD_CNT);
  localparam logic [15:0] BadLimit    = 16'(BAD_LIMIT);
  localparam logic [15:0] Window      = 16'(WINDOW);
  localparam logic [15:0] HuntTimeout = 16'(HUNT_TIMEOUT);
  localparam logic [15:0] FlushLast   = 16'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  good_run_q;
  logic [15:0] bad_run_q;
  logic [15:0] win_cnt_q;
  logic [15:0] bad_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        locked_q;
  logic        ena_q;
  logic        flush_q;
  logic        dout_valid_q;
  logic [7:0]  loss_cnt_q;

  logic        word_good;
  logic        word_bad;
  logic [7:0]  good_run_inc;
  logic [15:0] bad_run_inc;
  logic [15:0] win_cnt_inc;
  logic [15:0] bad_cnt_inc;

  assign word_good    = din_valid && (din == '0);
  assign word_bad     = din_valid && (din != '0);
  assign good_run_inc = good_run_q + 8'd1;
  assign bad_run_inc  = bad_run_q + 16'd1;
  assign win_cnt_inc  = win_cnt_q + 16'd1;
  assign bad_cnt_inc  = bad_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q      <= StHunt;
      good_run_q   <= '0;
      bad_run_q    <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      locked_q     <= 1'b0;
      ena_q        <= 1'b1;
      flush_q      <= 1'b0;
      dout_valid_q <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      // Qualify on the state at this edge: the lock-completing word is not passed on.
      dout_valid_q <= din_valid && (state_q == StLocked);
      unique case (state_q)
        StHunt: begin
          if (word_good) begin
            bad_run_q <= '0;
            if (good_run_inc == GoodCnt) begin
              state_q    <= StLocked;
              locked_q   <= 1'b1;
              good_run_q <= '0;
              win_cnt_q  <= '0;
              bad_cnt_q  <= '0;
            end else begin
              good_run_q <= good_run_inc;
            end
          end else if (word_bad) begin
            good_run_q <= '0;
            if (bad_run_inc == HuntTimeout) begin
              state_q     <= StFlush;
              flush_q     <= 1'b1;
              ena_q       <= 1'b0;
              flush_cnt_q <= '0;
              bad_run_q   <= '0;
            end else begin
              bad_run_q <= bad_run_inc;
            end
          end
        end
        StLocked: begin
          if (din_valid) begin
            // Limit is tested before the window roll so a hit on the last word still drops lock.
            if (word_bad && (bad_cnt_inc == BadLimit)) begin
              state_q    <= StHunt;
              locked_q   <= 1'b0;
              good_run_q <= '0;
              bad_run_q  <= '0;
              if (loss_cnt_q != 8'hff) begin
                loss_cnt_q <= loss_cnt_q + 8'd1;
              end
            end else if (win_cnt_inc == Window) begin
              win_cnt_q <= '0;
              bad_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_inc;
              if (word_bad) begin
                bad_cnt_q <= bad_cnt_inc;
              end
            end
          end
        end
        StFlush: begin
          if (flush_cnt_q == FlushLast) begin
            state_q    <= StHunt;
            flush_q    <= 1'b0;
            ena_q      <= 1'b1;
            good_run_q <= '0;
            bad_run_q  <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  assign descram_ena   = ena_q;
  assign descram_flush = flush_q;
  assign locked        = locked_q;
  assign dout_valid    = dout_valid_q;
  assign loss_cnt      = loss_cnt_q;
  assign state         = state_q;

`ifdef SCRAMBLER_SYNC_BIT_ERR_EN
  localparam int unsigned PopW = $clog2(WIDTH + 1);

  logic [PopW-1:0] pop_d;
  logic [PopW-1:0] pop_q;
  logic [15:0]     bit_err_q;
  logic [16:0]     bit_err_sum;

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_d = pop_d + PopW'(din[i]);
    end
  end

  assign bit_err_sum = {1'b0, bit_err_q} + 17'(pop_q);

  // Popcount is registered first, so the accumulated count trails the word by one extra cycle.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      pop_q     <= '0;
      bit_err_q <= '0;
    end else begin
      pop_q     <= (din_valid && (state_q == StLocked)) ? pop_d : '0;
      bit_err_q <= bit_err_sum[16] ? 16'hffff : bit_err_sum[15:0];
    end
  end

  assign bit_err_cnt = bit_err_q;
`else
  assign bit_err_cnt = '0;
`endif

endmodule

// File: tb/tb_scrambler_sync_ctrl.sv
// Scoreboard bench for scrambler_sync_ctrl: driver pushes expected status per cycle, monitor
// pops and compares after each rising edge; directed checks use hand-computed constants.
module tb_scrambler_sync_ctrl;
  localparam int unsigned W = 256;

  logic         clk;
  logic         srst_n;
  logic         din_valid;
  logic [W-1:0] din;
  logic         descram_ena;
  logic         descram_flush;
  logic         locked;
  logic         dout_valid;
  logic [7:0]   loss_cnt;
  logic [1:0]   state;
  logic [15:0]  bit_err_cnt;

  scrambler_sync_ctrl #(
    .WIDTH(W), .GOOD_CNT(8), .BAD_LIMIT(4), .WINDOW(64), .HUNT_TIMEOUT(32), .FLUSH_CYCLES(2)
  ) dut (
    .clk          (clk),
    .srst_n       (srst_n),
    .din_valid    (din_valid),
    .din          (din),
    .descram_ena  (descram_ena),
    .descram_flush(descram_flush),
    .locked       (locked),
    .dout_valid   (dout_valid),
    .loss_cnt     (loss_cnt),
    .state        (state),
    .bit_err_cnt  (bit_err_cnt)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        lk;
    logic        ena;
    logic        fl;
    logic        dv;
    logic [7:0]  loss;
    logic [15:0] bec;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef SCRAMBLER_SYNC_BIT_ERR_EN
  localparam logic [31:0] Exp261 = 32'd261;
  localparam logic [31:0] ExpSat = 32'd65535;
`else
  localparam logic [31:0] Exp261 = 32'd0;
  localparam logic [31:0] ExpSat = 32'd0;
`endif

  // Behavioural expectation, one call per clock edge.
  int m_st, m_good, m_bad, m_win, m_badc, m_frem, m_loss, m_pop, m_bec;
  bit m_lk, m_ena, m_fl, m_dv;

  logic [W-1:0] zero_w;
  logic [W-1:0] ones_w;
  logic [W-1:0] five_w;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic rst_n, input logic v, input logic [W-1:0] d);
    bit bad;
    bad = (d != '0);
    if (!rst_n) begin
      m_st = 0; m_good = 0; m_bad = 0; m_win = 0; m_badc = 0; m_frem = 0;
      m_loss = 0; m_pop = 0; m_bec = 0;
      m_lk = 0; m_ena = 1; m_fl = 0; m_dv = 0;
    end else begin
`ifdef SCRAMBLER_SYNC_BIT_ERR_EN
      m_bec = (m_bec + m_pop > 65535) ? 65535 : m_bec + m_pop;
      m_pop = (v && m_st == 1) ? $countones(d) : 0;
`endif
      m_dv = v && (m_st == 1);
      if (m_st == 0) begin
        if (v && !bad) begin
          m_bad = 0;
          m_good++;
          if (m_good == 8) begin
            m_st = 1; m_lk = 1; m_good = 0; m_win = 0; m_badc = 0;
          end
        end else if (v) begin
          m_good = 0;
          m_bad++;
          if (m_bad == 32) begin
            m_st = 2; m_fl = 1; m_ena = 0; m_frem = 2; m_bad = 0;
          end
        end
      end else if (m_st == 1) begin
        if (v) begin
          m_win++;
          if (bad) m_badc++;
          if (bad && m_badc == 4) begin
            m_st = 0; m_lk = 0; m_good = 0; m_bad = 0;
            m_loss = (m_loss == 255) ? 255 : m_loss + 1;
          end else if (m_win == 64) begin
            m_win = 0; m_badc = 0;
          end
        end
      end else begin
        m_frem--;
        if (m_frem == 0) begin
          m_st = 0; m_fl = 0; m_ena = 1; m_good = 0; m_bad = 0;
        end
      end
    end
  endtask

  // Drive one cycle starting at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic rst_n, input logic v, input logic [W-1:0] d);
    obs_t e;
    srst_n    = rst_n;
    din_valid = v;
    din       = d;
    model(rst_n, v, d);
    e = '{st: 2'(m_st), lk: m_lk, ena: m_ena, fl: m_fl, dv: m_dv, loss: 8'(m_loss),
          bec: 16'(m_bec)};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic words(input int n, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, d);
  endtask

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, locked, descram_ena, descram_flush, dout_valid, loss_cnt, bit_err_cnt};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL scoreboard t=%0t got st=%0d lk=%b ena=%b fl=%b dv=%b loss=%0d bec=%0d expected st=%0d lk=%b ena=%b fl=%b dv=%b loss=%0d bec=%0d",
                   $time, a.st, a.lk, a.ena, a.fl, a.dv, a.loss, a.bec,
                   e.st, e.lk, e.ena, e.fl, e.dv, e.loss, e.bec);
        end
      end
    end
  end

  initial begin : driver
    zero_w = '0;
    ones_w = '1;
    five_w = '0;
    five_w[4:0] = 5'h1f;

    // Reset state
    cyc(1'b0, 1'b0, zero_w);
    cyc(1'b0, 1'b1, ones_w);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ena", 32'(descram_ena), 32'd1);
    chk("rst_flush", 32'(descram_flush), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_loss", 32'(loss_cnt), 32'd0);
    chk("rst_bec", 32'(bit_err_cnt), 32'd0);

    // 8 clean words lock; the 8th does not produce dout_valid
    words(7, zero_w);
    chk("t1_locked_after7", 32'(locked), 32'd0);
    words(1, zero_w);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_state", 32'(state), 32'd1);
    chk("t1_dv_lockword", 32'(dout_valid), 32'd0);
    words(1, zero_w);
    chk("t1_dv", 32'(dout_valid), 32'd1);

    // 4 spread bad words drop lock; the loss word still qualifies dout_valid
    for (int k = 0; k < 4; k++) begin
      words(1, ones_w);
      if (k < 3) begin
        chk("t2_still_locked", 32'(locked), 32'd1);
        words(5, zero_w);
      end
    end
    chk("t2_locked", 32'(locked), 32'd0);
    chk("t2_state", 32'(state), 32'd0);
    chk("t2_loss", 32'(loss_cnt), 32'd1);
    chk("t2_dv_lossword", 32'(dout_valid), 32'd1);

    // 3 bad per window for 10 windows keeps lock; 4th on word 64 drops it
    words(8, zero_w);
    chk("t3_relock", 32'(locked), 32'd1);
    for (int w = 0; w < 10; w++) begin
      for (int i = 0; i < 64; i++) begin
        words(1, (i == 0 || i == 20 || i == 40) ? ones_w : zero_w);
      end
    end
    chk("t3_10win_locked", 32'(locked), 32'd1);
    chk("t3_10win_loss", 32'(loss_cnt), 32'd1);
    for (int i = 0; i < 63; i++) begin
      words(1, (i == 10 || i == 20 || i == 30) ? ones_w : zero_w);
    end
    chk("t3_word63_locked", 32'(locked), 32'd1);
    words(1, ones_w);
    chk("t3_word64_locked", 32'(locked), 32'd0);
    chk("t3_word64_loss", 32'(loss_cnt), 32'd2);

    // Hunt timeout -> flush held 2 cycles, then relock
    words(31, ones_w);
    chk("t4_bad31_state", 32'(state), 32'd0);
    words(1, ones_w);
    chk("t4_flush_state", 32'(state), 32'd2);
    chk("t4_flush1", 32'(descram_flush), 32'd1);
    chk("t4_ena1", 32'(descram_ena), 32'd0);
    words(1, zero_w);
    chk("t4_flush2", 32'(descram_flush), 32'd1);
    words(1, zero_w);
    chk("t4_flush_end", 32'(descram_flush), 32'd0);
    chk("t4_ena_back", 32'(descram_ena), 32'd1);
    chk("t4_hunt", 32'(state), 32'd0);
    words(7, zero_w);
    chk("t4_not_yet", 32'(locked), 32'd0);
    words(1, zero_w);
    chk("t4_lock", 32'(locked), 32'd1);
    words(4, ones_w);
    chk("t4_loss3", 32'(loss_cnt), 32'd3);
    words(7, zero_w);
    words(1, ones_w);
    words(7, zero_w);
    chk("t4_broken_run", 32'(locked), 32'd0);
    words(1, zero_w);
    chk("t4_final8", 32'(locked), 32'd1);

    // Reset during flush, then lock through din_valid gaps
    words(4, ones_w);
    words(32, ones_w);
    chk("t5_in_flush", 32'(descram_flush), 32'd1);
    cyc(1'b0, 1'b1, zero_w);
    chk("t5_rst_flush", 32'(descram_flush), 32'd0);
    chk("t5_rst_ena", 32'(descram_ena), 32'd1);
    chk("t5_rst_state", 32'(state), 32'd0);
    chk("t5_rst_loss", 32'(loss_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, ones_w);
      if (i == 7) chk("t5_gap_7valid", 32'(locked), 32'd0);
      cyc(1'b1, 1'b1, zero_w);
    end
    chk("t5_gap_lock", 32'(locked), 32'd1);

    // Bit-error accumulation and saturation
    words(1, five_w);
    words(1, ones_w);
    words(1, zero_w);
    chk("t6_bec261", 32'(bit_err_cnt), Exp261);
    words(61, zero_w);
    for (int w = 0; w < 90; w++) begin
      words(3, ones_w);
      words(61, zero_w);
    end
    words(2, zero_w);
    chk("t6_bec_sat", 32'(bit_err_cnt), ExpSat);
    chk("t6_locked", 32'(locked), 32'd1);
    chk("t6_loss", 32'(loss_cnt), 32'd0);

    cyc(1'b1, 1'b0, zero_w);
    @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
